// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped data cache.
// Holds the FSM state enum, address-field constants and the byte-lane selector.
package dcache_pkg;

    localparam int ADDR_W    = 8;
    localparam int OFFSET_W  = 2;
    localparam int INDEX_LSB = OFFSET_W;
    localparam int BYTE_W    = 8;
    localparam int BLOCK_W   = 32;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        UPDATE
    } state_t;

    function automatic logic [BYTE_W-1:0] select_byte(
        input logic [BLOCK_W-1:0]  block,
        input logic [OFFSET_W-1:0] offset
    );
        return block[{offset, 3'b000} +: BYTE_W];
    endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side data-memory port of the cache: load/store request in, data and stall out.
interface dcache_if;
    import dcache_pkg::*;

    logic              read;
    logic              write;
    logic [ADDR_W-1:0] ADDRESS;
    logic [BYTE_W-1:0] WRITEDATA;
    logic [BYTE_W-1:0] READDATA;
    logic              BUSYWAIT;

    modport master (
        output read, write, ADDRESS, WRITEDATA,
        input  READDATA, BUSYWAIT
    );

    modport slave (
        input  read, write, ADDRESS, WRITEDATA,
        output READDATA, BUSYWAIT
    );

endinterface

// File: rtl/dcache_ctrl.sv
// Miss-handling FSM and registered memory-side handshake for dcache_direct.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 3
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     req,
    input  logic                     hit,
    input  logic                     victim_dirty,
    input  logic [TAG_W-1:0]         req_tag,
    input  logic [INDEX_W-1:0]       req_index,
    input  logic [TAG_W-1:0]         victim_tag,
    input  logic [BLOCK_W-1:0]       victim_data,
    input  logic                     mem_busywait,
    output state_t                   state,
    output logic [TAG_W-1:0]         fill_tag,
    output logic [INDEX_W-1:0]       fill_index,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [TAG_W+INDEX_W-1:0] mem_address,
    output logic [BLOCK_W-1:0]       mem_writedata
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]              hit_count,
    output logic [15:0]              miss_count
`endif
);

    // The request fields are latched on the miss so a withdrawn request still fills the right line.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            fill_tag      <= '0;
            fill_index    <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !hit) begin
                        fill_tag   <= req_tag;
                        fill_index <= req_index;
                        if (victim_dirty) begin
                            state         <= WRITEBACK;
                            mem_write     <= 1'b1;
                            mem_address   <= {victim_tag, req_index};
                            mem_writedata <= victim_data;
                        end else begin
                            state       <= FETCH;
                            mem_read    <= 1'b1;
                            mem_address <= {req_tag, req_index};
                        end
                    end
                end
                WRITEBACK: begin
                    if (!mem_busywait) begin
                        state       <= FETCH;
                        mem_write   <= 1'b0;
                        mem_read    <= 1'b1;
                        mem_address <= {fill_tag, fill_index};
                    end
                end
                FETCH: begin
                    if (!mem_busywait) begin
                        state    <= UPDATE;
                        mem_read <= 1'b0;
                    end
                end
                UPDATE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic post_fill;

    // The hit that completes a fill is part of that miss, so post_fill keeps it out of hit_count.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hit_count  <= '0;
            miss_count <= '0;
            post_fill  <= 1'b0;
        end else begin
            post_fill <= (state == UPDATE);
            if (state == IDLE && req && hit && !post_fill && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (state == IDLE && req && !hit && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped, write-back, write-allocate data cache between a single-cycle CPU and block memory.
// Define DCACHE_STATS_EN to add the hit_count/miss_count outputs.
module dcache_direct
    import dcache_pkg::*;
#(
    parameter int INDEX_W = 3
) (
    input  logic                     CLK,
    input  logic                     RESET,
    dcache_if.slave                  cpu,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-OFFSET_W-1:0] mem_address,
    output logic [BLOCK_W-1:0]       mem_writedata,
    input  logic [BLOCK_W-1:0]       mem_readdata,
    input  logic                     mem_busywait
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]              hit_count,
    output logic [15:0]              miss_count
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]   valid_bits;
    logic [LINES-1:0]   dirty_bits;
    logic [TAG_W-1:0]   tag_array  [LINES];
    logic [BLOCK_W-1:0] data_array [LINES];

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [OFFSET_W-1:0] req_offset;
    logic                req;
    logic                hit;
    logic                write_hit;
    state_t              state;
    logic [TAG_W-1:0]    fill_tag;
    logic [INDEX_W-1:0]  fill_index;

    assign req_tag    = cpu.ADDRESS[ADDR_W-1 -: TAG_W];
    assign req_index  = cpu.ADDRESS[INDEX_LSB +: INDEX_W];
    assign req_offset = cpu.ADDRESS[OFFSET_W-1:0];
    assign req        = cpu.read || cpu.write;
    assign hit        = valid_bits[req_index] && (tag_array[req_index] == req_tag);
    assign write_hit  = cpu.write && (state == IDLE) && hit;

    // Stall is purely combinational so it rises in the same cycle a missing request appears.
    assign cpu.BUSYWAIT = !RESET && req && !((state == IDLE) && hit);
    assign cpu.READDATA = select_byte(data_array[req_index], req_offset);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (state == UPDATE) begin
            valid_bits[fill_index] <= 1'b1;
            dirty_bits[fill_index] <= 1'b0;
        end else if (write_hit) begin
            dirty_bits[req_index] <= 1'b1;
        end
    end

    // Line contents need no reset; valid_bits guard every use of them.
    always_ff @(posedge CLK) begin
        if (state == UPDATE) begin
            data_array[fill_index] <= mem_readdata;
            tag_array[fill_index]  <= fill_tag;
        end else if (write_hit) begin
            data_array[req_index][{req_offset, 3'b000} +: BYTE_W] <= cpu.WRITEDATA;
        end
    end

    dcache_ctrl #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_ctrl (
        .CLK           (CLK),
        .RESET         (RESET),
        .req           (req),
        .hit           (hit),
        .victim_dirty  (valid_bits[req_index] && dirty_bits[req_index]),
        .req_tag       (req_tag),
        .req_index     (req_index),
        .victim_tag    (tag_array[req_index]),
        .victim_data   (data_array[req_index]),
        .mem_busywait  (mem_busywait),
        .state         (state),
        .fill_tag      (fill_tag),
        .fill_index    (fill_index),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

endmodule

// File: tb/tb_dcache_direct.sv
// Scoreboard bench for dcache_direct: expected load bytes and memory transfers are queued
// when a request is driven and compared when the cache or the memory model completes them.
module tb_dcache_direct;
    import dcache_pkg::*;

    typedef struct {
        bit          is_write;
        logic [5:0]  addr;
        logic [31:0] data;
    } mem_exp_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = '0;
    logic        mem_busywait;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int check_count = 0;
    int fail_count  = 0;
    int mem_latency = 5;
    int busy_cnt    = 0;
    bit mem_ready   = 1'b0;

    logic [31:0] mem_model [64];
    logic [7:0]  exp_read_q [$];
    mem_exp_t    exp_mem_q [$];

    dcache_if cpu_bus ();

    dcache_direct dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .cpu           (cpu_bus.slave),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    // Memory model: each byte of a block encodes its lane and block address.
    assign mem_busywait = (mem_read || mem_write) && (busy_cnt < mem_latency);

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            busy_cnt <= 0;
            if (!mem_ready) begin
                for (int a = 0; a < 64; a++)
                    mem_model[a] <= {2'b11, 6'(a), 2'b10, 6'(a), 2'b01, 6'(a), 2'b00, 6'(a)};
                mem_model[9] <= 32'hDDCCBBAA;
                mem_ready    <= 1'b1;
            end
        end else if (mem_read || mem_write) begin
            if (busy_cnt >= mem_latency) begin
                busy_cnt <= 0;
                if (mem_write) mem_model[mem_address] <= mem_writedata;
            end else begin
                busy_cnt <= busy_cnt + 1;
            end
            if (mem_read) mem_readdata <= mem_model[mem_address];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, required %h", tag, actual, expected);
        end
    endtask

    // Memory-side scoreboard: every completed transfer must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (!RESET && (mem_read || mem_write) && !mem_busywait) begin
            checkOutput("mem_exclusive", 32'(mem_read & mem_write), 32'd0);
            if (exp_mem_q.size() == 0) begin
                checkOutput("mem_unexpected", {25'd0, mem_write, mem_address}, 32'hFFFF_FFFF);
            end else begin
                mem_exp_t e;
                e = exp_mem_q.pop_front();
                checkOutput("mem_kind", 32'(mem_write), 32'(e.is_write));
                checkOutput("mem_addr", 32'(mem_address), 32'(e.addr));
                if (e.is_write) checkOutput("mem_wdata", mem_writedata, e.data);
            end
        end
    end

    task automatic applyStimulus(input bit is_write, input logic [7:0] addr,
                                 input logic [7:0] wdata, input logic [7:0] exp_rdata,
                                 input int exp_stalls);
        int  stalls;
        bit  done;
        @(posedge CLK);
        #1;
        cpu_bus.read      = !is_write;
        cpu_bus.write     = is_write;
        cpu_bus.ADDRESS   = addr;
        cpu_bus.WRITEDATA = wdata;
        if (!is_write) exp_read_q.push_back(exp_rdata);
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge CLK);
            if (cpu_bus.BUSYWAIT) begin
                stalls++;
            end else begin
                done = 1'b1;
                if (!is_write) checkOutput("readdata", 32'(cpu_bus.READDATA), 32'(exp_read_q.pop_front()));
            end
        end
        if (!done) checkOutput("busywait_timeout", 32'd1, 32'd0);
        checkOutput("stall_cycles", 32'(stalls), 32'(exp_stalls));
        @(posedge CLK);
        #1;
        cpu_bus.read  = 1'b0;
        cpu_bus.write = 1'b0;
    endtask

    initial begin
        int clean_miss;
        int dirty_miss;
        clean_miss = mem_latency + 3;
        dirty_miss = 2 * mem_latency + 4;
        cpu_bus.read      = 1'b0;
        cpu_bus.write     = 1'b0;
        cpu_bus.ADDRESS   = '0;
        cpu_bus.WRITEDATA = '0;

        repeat (2) @(posedge CLK);
        #1;
        checkOutput("rst_busywait", 32'(cpu_bus.BUSYWAIT), 32'd0);
        checkOutput("rst_mem_read", 32'(mem_read), 32'd0);
        checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
        checkOutput("rst_mem_address", 32'(mem_address), 32'd0);
        checkOutput("rst_mem_writedata", mem_writedata, 32'd0);
        RESET = 1'b0;

        $display("[TB] cold read miss, read hit, write hit");
        exp_mem_q.push_back('{1'b0, 6'h09, 32'h0});
        applyStimulus(1'b0, 8'h25, 8'h00, 8'hBB, clean_miss);
        applyStimulus(1'b0, 8'h27, 8'h00, 8'hDD, 0);
        applyStimulus(1'b1, 8'h25, 8'h5A, 8'h00, 0);

        $display("[TB] dirty eviction and clean write miss");
        exp_mem_q.push_back('{1'b1, 6'h09, 32'hDDCC5AAA});
        exp_mem_q.push_back('{1'b0, 6'h11, 32'h0});
        applyStimulus(1'b0, 8'h45, 8'h00, 8'h51, dirty_miss);
        exp_mem_q.push_back('{1'b0, 6'h20, 32'h0});
        applyStimulus(1'b1, 8'h80, 8'h11, 8'h00, clean_miss);

`ifdef DCACHE_STATS_EN
        checkOutput("hit_count", 32'(hit_count), 32'd2);
        checkOutput("miss_count", 32'(miss_count), 32'd3);
        force dut.u_ctrl.hit_count = 16'hFFFF;
        @(negedge CLK);
        release dut.u_ctrl.hit_count;
`endif

        // The stored byte must be readable at once, and its line must come back dirty.
        applyStimulus(1'b0, 8'h80, 8'h00, 8'h11, 0);
`ifdef DCACHE_STATS_EN
        checkOutput("hit_count_sat", 32'(hit_count), 32'h0000FFFF);
`endif
        exp_mem_q.push_back('{1'b1, 6'h20, 32'hE0A06011});
        exp_mem_q.push_back('{1'b0, 6'h28, 32'h0});
        applyStimulus(1'b0, 8'hA0, 8'h00, 8'h28, dirty_miss);

        $display("[TB] reset during fetch");
        @(posedge CLK);
        #1;
        cpu_bus.read    = 1'b1;
        cpu_bus.ADDRESS = 8'h25;
        repeat (3) @(negedge CLK);
        checkOutput("fetch_mem_read", 32'(mem_read), 32'd1);
        checkOutput("fetch_mem_address", 32'(mem_address), 32'h09);
        #2;
        RESET = 1'b1;
        #1;
        checkOutput("abort_mem_read", 32'(mem_read), 32'd0);
        checkOutput("abort_busywait", 32'(cpu_bus.BUSYWAIT), 32'd0);
        @(posedge CLK);
        #1;
        cpu_bus.read = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        // Block 0x09 now holds the earlier written-back line.
        exp_mem_q.push_back('{1'b0, 6'h09, 32'h0});
        applyStimulus(1'b0, 8'h25, 8'h00, 8'h5A, clean_miss);

        $display("[TB] store withdrawn mid-fill");
        exp_mem_q.push_back('{1'b0, 6'h19, 32'h0});
        @(posedge CLK);
        #1;
        cpu_bus.write     = 1'b1;
        cpu_bus.ADDRESS   = 8'h65;
        cpu_bus.WRITEDATA = 8'hFF;
        repeat (3) @(negedge CLK);
        @(posedge CLK);
        #1;
        cpu_bus.write = 1'b0;
        repeat (mem_latency + 4) @(posedge CLK);
        applyStimulus(1'b0, 8'h65, 8'h00, 8'h59, 0);

        repeat (2) @(posedge CLK);
        checkOutput("mem_pending", 32'(exp_mem_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
